// File: rtl/gated_d_latch_pkg.sv
// Shared flip-flop/latch library definitions: enable levels, reset default and output select helper.
package gated_d_latch_pkg;

  localparam int unsigned LATCH_SLICE_W = 1;

  localparam logic DEFAULT_RESET_BIT = 1'b0;

  typedef enum logic {
    LATCH_HOLD        = 1'b0,
    LATCH_TRANSPARENT = 1'b1
  } latch_en_e;

  // Output select for one slice: live data while transparent, stored value while holding.
  function automatic logic latch_sel(input logic e, input logic d, input logic hold);
    return (latch_en_e'(e) == LATCH_TRANSPARENT) ? d : hold;
  endfunction

endpackage

// File: rtl/gated_d_latch_bit.sv
// One-bit gated D latch slice: clocked hold flop plus combinational transparent/hold mux and inverter.
module gated_d_latch_bit
  import gated_d_latch_pkg::*;
#(
  parameter logic RESET_BIT = DEFAULT_RESET_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  input  logic e_i,
  output logic q_c,
  output logic q_bar_c
);

  logic hold_q;
  logic hold_d;

  // Hold register tracks D only while the latch is open.
  always_comb begin
    hold_d = hold_q;
    if (latch_en_e'(e_i) == LATCH_TRANSPARENT) begin
      hold_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= RESET_BIT;
    end else begin
      hold_q <= hold_d;
    end
  end

  // Reset overrides the mux so Q reflects reset without waiting for a clock edge.
  always_comb begin
    q_c = RESET_BIT;
    if (rst_n) begin
      q_c = latch_sel(e_i, d_i, hold_q);
    end
    q_bar_c = ~q_c;
  end

endmodule

// File: rtl/gated_d_latch.sv
// WIDTH-bit gated D latch built from independent per-bit slices sharing clock, reset and enable.
module gated_d_latch
  import gated_d_latch_pkg::*;
#(
  parameter int unsigned       WIDTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             E,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar
);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    gated_d_latch_bit #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_i     (D[i]),
      .e_i     (E),
      .q_c     (Q[i]),
      .q_bar_c (Q_bar[i])
    );
  end

endmodule

// File: tb/tb_gated_d_latch.sv
// Scoreboard bench for gated_d_latch: directed vectors on 1-, 4- and 8-bit instances.
module tb_gated_d_latch;

  logic       clk = 1'b0;
  logic       rst_n1, rst_n4, rst_n8;
  logic [0:0] d1, q1, qb1;
  logic [3:0] d4, q4, qb4;
  logic [7:0] d8, q8, qb8;
  logic       e1, e4, e8;

  always #5 clk = ~clk;

  gated_d_latch #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .D(d1), .E(e1), .Q(q1), .Q_bar(qb1)
  );
  gated_d_latch #(.WIDTH(4), .RESET_VALUE(4'b1001)) dut4 (
    .clk(clk), .rst_n(rst_n4), .D(d4), .E(e4), .Q(q4), .Q_bar(qb4)
  );
  gated_d_latch #(.WIDTH(8), .RESET_VALUE(8'h00)) dut8 (
    .clk(clk), .rst_n(rst_n8), .D(d8), .E(e8), .Q(q8), .Q_bar(qb8)
  );

  string      name_q[$];
  int         sel_q[$];
  logic [7:0] expq_q[$];
  logic [7:0] expqb_q[$];
  event       chk_ev;

  int n_tests = 0;
  int n_fail  = 0;

  // Push one expectation; the monitor compares it against the selected instance.
  task automatic expect_out(input string nm, input int sel, input logic [7:0] eq, input logic [7:0] eqb);
    name_q.push_back(nm);
    sel_q.push_back(sel);
    expq_q.push_back(eq);
    expqb_q.push_back(eqb);
    -> chk_ev;
    #1;
  endtask

  initial begin : monitor
    string      nm;
    int         sel;
    logic [7:0] eq, eqb, aq, aqb;
    forever begin
      @(chk_ev);
      while (name_q.size() != 0) begin
        nm  = name_q.pop_front();
        sel = sel_q.pop_front();
        eq  = expq_q.pop_front();
        eqb = expqb_q.pop_front();
        case (sel)
          1:       begin aq = {7'b0, q1}; aqb = {7'b0, qb1}; end
          4:       begin aq = {4'b0, q4}; aqb = {4'b0, qb4}; end
          default: begin aq = q8;         aqb = qb8;         end
        endcase
        n_tests++;
        if (aq !== eq || aqb !== eqb) begin
          n_fail++;
          $display("FAIL %s: Q=%h Q_bar=%h, required Q=%h Q_bar=%h", nm, aq, aqb, eq, eqb);
        end
      end
    end
  end

  initial begin : stim
    rst_n1 = 1'b0; rst_n4 = 1'b0; rst_n8 = 1'b0;
    d1 = 1'b0; e1 = 1'b0;
    d4 = 4'h0; e4 = 1'b0;
    d8 = 8'h00; e8 = 1'b0;

    // Width 1: reset and init
    repeat (2) @(negedge clk);
    expect_out("w1_in_reset", 1, 8'h00, 8'h01);
    @(negedge clk); rst_n1 = 1'b1;
    expect_out("w1_after_reset", 1, 8'h00, 8'h01);

    // Transparent, D change visible without an edge
    @(negedge clk); e1 = 1'b1; d1 = 1'b0;
    expect_out("w1_transp_d0", 1, 8'h00, 8'h01);
    d1 = 1'b1;
    expect_out("w1_transp_d1_no_edge", 1, 8'h01, 8'h00);

    // Hold after D was stable across an edge
    @(negedge clk); e1 = 1'b0;
    expect_out("w1_hold_1", 1, 8'h01, 8'h00);
    d1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_out("w1_hold_1_d0", 1, 8'h01, 8'h00);
    end

    // Reopen then hold 0 across D toggles
    @(negedge clk); e1 = 1'b1; d1 = 1'b0;
    expect_out("w1_reopen_d0", 1, 8'h00, 8'h01);
    @(negedge clk); e1 = 1'b0;
    expect_out("w1_hold_0", 1, 8'h00, 8'h01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); d1 = ~d1;
      expect_out("w1_hold_0_toggle", 1, 8'h00, 8'h01);
    end

    // Closing in the same cycle D changes keeps the sampled D
    @(negedge clk); e1 = 1'b1; d1 = 1'b1;
    @(negedge clk); e1 = 1'b0; d1 = 1'b0;
    expect_out("w1_close_same_cycle", 1, 8'h01, 8'h00);

    // Async reset mid-hold, between edges
    @(negedge clk); rst_n1 = 1'b0;
    expect_out("w1_async_reset", 1, 8'h00, 8'h01);
    e1 = 1'b1; d1 = 1'b1;
    expect_out("w1_reset_e1_d1", 1, 8'h00, 8'h01);
    @(negedge clk);
    expect_out("w1_reset_across_edge", 1, 8'h00, 8'h01);
    rst_n1 = 1'b1;
    expect_out("w1_release_transp", 1, 8'h01, 8'h00);
    e1 = 1'b0;
    expect_out("w1_close_before_edge", 1, 8'h00, 8'h01);
    e1 = 1'b1;
    @(negedge clk); e1 = 1'b0;
    expect_out("w1_hold_after_edge", 1, 8'h01, 8'h00);

    // Width 4 with non-zero reset value
    expect_out("w4_in_reset", 4, 8'h09, 8'h06);
    @(negedge clk); rst_n4 = 1'b1;
    expect_out("w4_release_hold", 4, 8'h09, 8'h06);
    e4 = 1'b1; d4 = 4'h3;
    expect_out("w4_transp", 4, 8'h03, 8'h0C);
    @(negedge clk); e4 = 1'b0; d4 = 4'hF;
    expect_out("w4_hold", 4, 8'h03, 8'h0C);
    rst_n4 = 1'b0;
    expect_out("w4_reset_again", 4, 8'h09, 8'h06);

    // Width 8
    expect_out("w8_in_reset", 8, 8'h00, 8'hFF);
    @(negedge clk); rst_n8 = 1'b1; e8 = 1'b1; d8 = 8'hA5;
    repeat (2) @(negedge clk);
    expect_out("w8_transp_a5", 8, 8'hA5, 8'h5A);
    e8 = 1'b0; d8 = 8'h3C;
    expect_out("w8_hold_a5", 8, 8'hA5, 8'h5A);
    @(negedge clk);
    expect_out("w8_hold_a5_edge", 8, 8'hA5, 8'h5A);
    rst_n8 = 1'b0;
    expect_out("w8_reset", 8, 8'h00, 8'hFF);

    #2;
    n_tests++;
    if (name_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", name_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
